// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access; round-robin on ties.
// Latency: grant on the edge after a request, bus_valid the next cycle, ready pulse one cycle after bus_ack.
// Backpressure: requesters hold until their ready pulse; the slave stretches via bus_ack; mem_ready low while any request waits.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   if_req/if_addr          - fetch request in; if_rdata/if_ready completion out
//   d_req/d_we/d_be/d_addr/d_wdata - data request in; d_rdata/d_ready completion out
//   flush                   - taken branch; cancels a waiting or in-flight fetch
//   mem_ready               - low while any request is outstanding (ID-stage stall)
//   bus_*                   - registered single-outstanding bus master, bus_ack/bus_rdata from slave
//   stall_cycles            - saturating count of cycles with mem_ready low
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    input  logic                flush,
    output logic                mem_ready,
    output logic                bus_valid,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic                last_if_q,   last_if_d;
    logic                bus_valid_q, bus_valid_d;
    logic                bus_we_q,    bus_we_d;
    logic [BE_W-1:0]     bus_be_q,    bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic                if_ready_q,  if_ready_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                d_ready_q,   d_ready_d;
    logic [CNT_W-1:0]    stall_q,     stall_d;

    logic if_elig;
    logic d_elig;
    logic grant_d;
    logic grant_if;

    // A requester whose ready pulse is showing has already been served this
    // cycle; its request line is stale until it reacts next cycle.
    assign if_elig  = if_req && !flush && !if_ready_q;
    assign d_elig   = d_req && !d_ready_q;
    // last_if_q = 1 means fetch won the previous grant, so data wins a tie.
    assign grant_d  = d_elig && (!if_elig || last_if_q);
    assign grant_if = if_elig && !grant_d;

    assign mem_ready = !((if_req && !if_ready_q) || (d_req && !d_ready_q));

    always_comb begin
        state_d     = state_q;
        last_if_d   = last_if_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    bus_valid_d = 1'b1;
                    bus_we_d    = d_we;
                    bus_be_d    = d_be;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    last_if_d   = 1'b0;
                    state_d     = BUSY_D;
                end else if (grant_if) begin
                    bus_valid_d = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr;
                    last_if_d   = 1'b1;
                    state_d     = BUSY_IF;
                end
            end
            BUSY_D: begin
                if (bus_ack) begin
                    bus_valid_d = 1'b0;
                    d_ready_d   = 1'b1;
                    if (!bus_we_q) begin
                        d_rdata_d = bus_rdata;
                    end
                    state_d = IDLE;
                end
            end
            BUSY_IF: begin
                // A flush on the ack edge still discards the returned word.
                if (bus_ack) begin
                    bus_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (!flush) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The slave cannot abort, so the cancelled fetch still runs to ack.
                if (bus_ack) begin
                    bus_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!mem_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_if_q   <= 1'b1;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_if_q   <= last_if_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_ready_q   <= d_ready_d;
            stall_q     <= stall_d;
        end
    end

    assign bus_valid    = bus_valid_q;
    assign bus_we       = bus_we_q;
    assign bus_be       = bus_be_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign if_ready     = if_ready_q;
    assign d_rdata      = d_rdata_q;
    assign d_ready      = d_ready_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        flush;
    logic        mem_ready;
    logic        bus_valid;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [3:0]  stall_cycles;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .flush(flush), .mem_ready(mem_ready),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic zero_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0;
        d_wdata = 0; flush = 0; bus_rdata = 0; bus_ack = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
    endtask

    // Leaves the bench one time unit after the first edge out of reset (cycle 0).
    task automatic apply_reset();
        zero_inputs();
        reset = 0;
        @(posedge clock); @(posedge clock);
        @(negedge clock) reset = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        zero_inputs();
        reset = 0;
        #12;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_bus_valid: got %b want 0", bus_valid); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we: got %b want 0", bus_we); end
        checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL rst_bus_be: got %h want 0", bus_be); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
        checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_bus_wdata: got %h want 0", bus_wdata); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready: got %b want 0", if_ready); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready: got %b want 0", d_ready); end
        checks++; if (stall_cycles !== 4'h0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rst_mem_ready: got %b want 1", mem_ready); end
        @(negedge clock) reset = 1;
        next_cycle();
    endtask

    task automatic test_fetch();
        apply_reset();
        if_req = 1; if_addr = 32'h100;
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fetch_mr_c0: got %b want 0", mem_ready); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_c0: got %b want 0", bus_valid); end
        next_cycle();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid_c1: got %b want 1", bus_valid); end
        checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h want 100", bus_addr); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL fetch_we: got %b want 0", bus_we); end
        checks++; if (bus_be !== 4'hF) begin errors++; $display("FAIL fetch_be: got %h want f", bus_be); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fetch_mr_c1: got %b want 0", mem_ready); end
        bus_ack = 1; bus_rdata = 32'h13;
        next_cycle();
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready: got %b want 1", if_ready); end
        checks++; if (if_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata: got %h want 13", if_rdata); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_c2: got %b want 0", bus_valid); end
        checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL fetch_stall: got %0d want 2", stall_cycles); end
        if_req = 0; bus_ack = 0; bus_rdata = 32'hFFFF_0000;
        next_cycle();
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_c3: got %b want 0", if_ready); end
        checks++; if (if_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata_hold: got %h want 13", if_rdata); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL fetch_mr_c3: got %b want 1", mem_ready); end
        checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL fetch_stall_c3: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2000;
        if_req = 1; if_addr = 32'h104;
        next_cycle();
        checks++; if (bus_addr !== 32'h2000) begin errors++; $display("FAIL sim_first_addr: got %h want 2000", bus_addr); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL sim_first_we: got %b want 0", bus_we); end
        bus_ack = 1; bus_rdata = 32'hAAAA5555;
        next_cycle();
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL sim_d_ready: got %b want 1", d_ready); end
        checks++; if (d_rdata !== 32'hAAAA5555) begin errors++; $display("FAIL sim_d_rdata: got %h want aaaa5555", d_rdata); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL sim_gap_valid: got %b want 0", bus_valid); end
        d_req = 0; bus_rdata = 32'h11111111;
        next_cycle();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL sim_if_valid: got %b want 1", bus_valid); end
        checks++; if (bus_addr !== 32'h104) begin errors++; $display("FAIL sim_if_addr: got %h want 104", bus_addr); end
        checks++; if (bus_be !== 4'hF) begin errors++; $display("FAIL sim_if_be: got %h want f", bus_be); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL sim_if_early: got %b want 0", if_ready); end
        next_cycle();
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL sim_if_ready: got %b want 1", if_ready); end
        checks++; if (if_rdata !== 32'h11111111) begin errors++; $display("FAIL sim_if_rdata: got %h want 11111111", if_rdata); end
        checks++; if (d_rdata !== 32'hAAAA5555) begin errors++; $display("FAIL sim_d_hold: got %h want aaaa5555", d_rdata); end
        if_req = 0; bus_ack = 0;
        next_cycle();
    endtask

    task automatic test_store_wait();
        apply_reset();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF;
        bus_rdata = 32'h12345678; bus_ack = 0;
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL st_valid c%0d: got %b want 1", c, bus_valid); end
            checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL st_we c%0d: got %b want 1", c, bus_we); end
            checks++; if (bus_be !== 4'b0011) begin errors++; $display("FAIL st_be c%0d: got %h want 3", c, bus_be); end
            checks++; if (bus_addr !== 32'h3000) begin errors++; $display("FAIL st_addr c%0d: got %h want 3000", c, bus_addr); end
            checks++; if (bus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_wdata c%0d: got %h want deadbeef", c, bus_wdata); end
            checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL st_early c%0d: got %b want 0", c, d_ready); end
            if (c == 4) bus_ack = 1;
            next_cycle();
        end
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL st_ready: got %b want 1", d_ready); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL st_rdata: got %h want 0", d_rdata); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL st_done_valid: got %b want 0", bus_valid); end
        d_req = 0; bus_ack = 0;
        next_cycle();
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL st_single_pulse: got %b want 0", d_ready); end
    endtask

    task automatic test_flush();
        apply_reset();
        if_req = 1; if_addr = 32'h180;
        next_cycle();
        checks++; if (bus_addr !== 32'h180) begin errors++; $display("FAIL fl_addr_c1: got %h want 180", bus_addr); end
        flush = 1; if_addr = 32'h200;
        next_cycle();
        flush = 0;
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL fl_valid_c2: got %b want 1", bus_valid); end
        checks++; if (bus_addr !== 32'h180) begin errors++; $display("FAIL fl_addr_c2: got %h want 180", bus_addr); end
        next_cycle();
        checks++; if (bus_addr !== 32'h180) begin errors++; $display("FAIL fl_addr_c3: got %h want 180", bus_addr); end
        bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
        next_cycle();
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fl_no_pulse: got %b want 0", if_ready); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL fl_rdata_kept: got %h want 0", if_rdata); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL fl_valid_c4: got %b want 0", bus_valid); end
        bus_ack = 0;
        next_cycle();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL fl_refetch_valid: got %b want 1", bus_valid); end
        checks++; if (bus_addr !== 32'h200) begin errors++; $display("FAIL fl_refetch_addr: got %h want 200", bus_addr); end
        bus_ack = 1; bus_rdata = 32'h600D600D;
        next_cycle();
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fl_refetch_ready: got %b want 1", if_ready); end
        checks++; if (if_rdata !== 32'h600D600D) begin errors++; $display("FAIL fl_refetch_rdata: got %h want 600d600d", if_rdata); end
        if_req = 0; bus_ack = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h4000;
        next_cycle();
        next_cycle();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", bus_valid); end
        #2 reset = 0;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_drop: got %b want 0", bus_valid); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 0", bus_addr); end
        checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL rm_be: got %h want 0", bus_be); end
        checks++; if (stall_cycles !== 4'h0) begin errors++; $display("FAIL rm_stall: got %0d want 0", stall_cycles); end
        @(negedge clock) reset = 1;
        next_cycle();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rm_regrant: got %b want 1", bus_valid); end
        checks++; if (bus_addr !== 32'h4000) begin errors++; $display("FAIL rm_regrant_addr: got %h want 4000", bus_addr); end
        checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL rm_stall_after: got %0d want 1", stall_cycles); end
        bus_ack = 1; bus_rdata = 32'h77;
        next_cycle();
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", d_ready); end
        checks++; if (d_rdata !== 32'h77) begin errors++; $display("FAIL rm_rdata: got %h want 77", d_rdata); end
        d_req = 0; bus_ack = 0;
        next_cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        if_req = 1; if_addr = 32'h500;
        for (int k = 1; k <= 21; k++) begin
            next_cycle();
            checks++;
            if (stall_cycles !== ((k > 15) ? 4'd15 : 4'(k))) begin
                errors++; $display("FAIL sat_stall c%0d: got %0d want %0d", k, stall_cycles, (k > 15) ? 15 : k);
            end
        end
        bus_ack = 1;
        next_cycle();
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL sat_ready: got %b want 1", if_ready); end
        checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", stall_cycles); end
        if_req = 0; bus_ack = 0;
        next_cycle();
    endtask

    // Transaction-level reference: at most one bus transfer owned by fetch or data.
    task automatic test_random();
        logic        m_busy, m_owner_if, m_cancel, m_last_if;
        logic        m_we;
        logic [3:0]  m_be;
        logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
        logic        m_if_ready, m_d_ready;
        int          m_stall;
        logic        waiting, e_if, e_d, n_if_ready, n_d_ready;
        apply_reset();
        m_busy = 0; m_owner_if = 0; m_cancel = 0; m_last_if = 1;
        m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        m_if_rdata = 0; m_d_rdata = 0; m_if_ready = 0; m_d_ready = 0; m_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (bus_valid !== m_busy) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, bus_valid, m_busy); end
            if (m_busy) begin
                checks++; if (bus_addr !== m_addr) begin errors++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, bus_addr, m_addr); end
                checks++; if (bus_we !== m_we) begin errors++; $display("FAIL rnd_we @%0d: got %b want %b", cyc, bus_we, m_we); end
                checks++; if (bus_be !== m_be) begin errors++; $display("FAIL rnd_be @%0d: got %h want %h", cyc, bus_be, m_be); end
                if (!m_owner_if) begin
                    checks++; if (bus_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata @%0d: got %h want %h", cyc, bus_wdata, m_wdata); end
                end
            end
            checks++; if (if_ready !== m_if_ready) begin errors++; $display("FAIL rnd_if_ready @%0d: got %b want %b", cyc, if_ready, m_if_ready); end
            checks++; if (d_ready !== m_d_ready) begin errors++; $display("FAIL rnd_d_ready @%0d: got %b want %b", cyc, d_ready, m_d_ready); end
            checks++; if (if_rdata !== m_if_rdata) begin errors++; $display("FAIL rnd_if_rdata @%0d: got %h want %h", cyc, if_rdata, m_if_rdata); end
            checks++; if (d_rdata !== m_d_rdata) begin errors++; $display("FAIL rnd_d_rdata @%0d: got %h want %h", cyc, d_rdata, m_d_rdata); end
            checks++; if (stall_cycles !== 4'(m_stall)) begin errors++; $display("FAIL rnd_stall @%0d: got %0d want %0d", cyc, stall_cycles, m_stall); end

            // Requesters: hold until served, then either chain a new request or go quiet.
            if (if_req && m_if_ready) begin
                if ($urandom_range(1, 0) == 1) if_addr = $urandom; else if_req = 0;
            end else if (!if_req && $urandom_range(2, 0) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            flush = ($urandom_range(7, 0) == 0);
            if (flush && if_req) if_addr = $urandom;
            if (d_req && m_d_ready) begin
                d_req = 0;
            end else if (!d_req && $urandom_range(2, 0) == 0) begin
                d_req = 1; d_we = 1'($urandom); d_be = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            bus_ack = ($urandom_range(2, 0) == 0);
            bus_rdata = $urandom;
            #1;

            waiting = (if_req && !m_if_ready) || (d_req && !m_d_ready);
            checks++; if (mem_ready !== !waiting) begin errors++; $display("FAIL rnd_mem_ready @%0d: got %b want %b", cyc, mem_ready, !waiting); end

            // Effect of the coming clock edge.
            if (waiting && m_stall < 15) m_stall = m_stall + 1;
            n_if_ready = 0; n_d_ready = 0;
            if (m_busy) begin
                if (m_owner_if && flush) m_cancel = 1;
                if (bus_ack) begin
                    m_busy = 0;
                    if (m_owner_if) begin
                        if (!m_cancel) begin n_if_ready = 1; m_if_rdata = bus_rdata; end
                    end else begin
                        n_d_ready = 1;
                        if (!m_we) m_d_rdata = bus_rdata;
                    end
                end
            end else begin
                e_if = if_req && !flush && !m_if_ready;
                e_d  = d_req && !m_d_ready;
                if (e_d && (!e_if || m_last_if)) begin
                    m_busy = 1; m_owner_if = 0; m_cancel = 0; m_last_if = 0;
                    m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
                end else if (e_if) begin
                    m_busy = 1; m_owner_if = 1; m_cancel = 0; m_last_if = 1;
                    m_we = 0; m_be = 4'hF; m_addr = if_addr;
                end
            end
            m_if_ready = n_if_ready;
            m_d_ready  = n_d_ready;
            next_cycle();
        end
        zero_inputs();
        next_cycle();
    endtask

    initial begin
        zero_inputs();
        reset = 0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store_wait();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
